// File: rtl/wb_ram512x8_ctrl.sv
// Wishbone-classic slave bridging 32-bit word accesses onto the 8-bit port
// of the 512x8 SRAM wrapper: four byte slots per access, little-endian.
module wb_ram512x8_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [6:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        ram_wen_o,
    output logic [8:0]  ram_adr_o,
    output logic [7:0]  ram_dat_o,
    input  logic [7:0]  ram_dat_i
);

    localparam int unsigned WORD_AW = 7;
    localparam int unsigned BYTE_AW = 9;
    localparam int unsigned DW      = 32;

    typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [WORD_AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic [3:0]          sel_q, sel_d;
    logic [DW-1:0]       asm_q, asm_d;
    // Read pipeline tags: an address was registered one / two edges ago.
    logic                p1_q, p1_d;
    logic                p2_q, p2_d;
    logic [DW-1:0]       wb_dat_d;
    logic                wb_ack_d;
    logic                ram_wen_d;
    logic [BYTE_AW-1:0]  ram_adr_d;
    logic [7:0]          ram_dat_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        asm_d     = asm_q;
        p1_d      = 1'b0;
        p2_d      = p1_q;
        wb_dat_d  = '0;
        wb_ack_d  = 1'b0;
        ram_wen_d = 1'b0;
        ram_adr_d = ram_adr_o;
        ram_dat_d = ram_dat_o;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                    adr_d     = wb_adr_i;
                    dat_d     = wb_dat_i;
                    sel_d     = wb_sel_i;
                    k_d       = 2'd1;
                    // Slot 0 is issued on the accepting edge itself.
                    ram_adr_d = {wb_adr_i, 2'd0};
                    if (wb_we_i) begin
                        ram_dat_d = wb_dat_i[7:0];
                        ram_wen_d = wb_sel_i[0];
                        state_d   = WR;
                    end else begin
                        p1_d    = 1'b1;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                // k wraps to 0 after slot 3; k == 0 here marks completion.
                if (k_q == 2'd0) begin
                    wb_ack_d = wb_cyc_i;
                    state_d  = ACK;
                end else begin
                    ram_adr_d = {adr_q, k_q};
                    ram_dat_d = dat_q[{k_q, 3'b000} +: 8];
                    ram_wen_d = sel_q[k_q];
                    k_d       = k_q + 2'd1;
                end
            end
            RD: begin
                if (k_q != 2'd0) begin
                    ram_adr_d = {adr_q, k_q};
                    k_d       = k_q + 2'd1;
                    p1_d      = 1'b1;
                end
                if (p2_q) begin
                    asm_d = {ram_dat_i, asm_q[DW-1:8]};
                    // Last byte: nothing issued one edge ago.
                    if (!p1_q) begin
                        wb_dat_d = {ram_dat_i, asm_q[DW-1:8]};
                        wb_ack_d = wb_cyc_i;
                        state_d  = ACK;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs; synchronous reset wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            asm_q     <= '0;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            ram_wen_o <= 1'b0;
            ram_adr_o <= '0;
            ram_dat_o <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            asm_q     <= asm_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            wb_dat_o  <= wb_dat_d;
            wb_ack_o  <= wb_ack_d;
            ram_wen_o <= ram_wen_d;
            ram_adr_o <= ram_adr_d;
            ram_dat_o <= ram_dat_d;
        end
    end

endmodule

// File: tb/tb_wb_ram512x8_ctrl.sv
// Bench for wb_ram512x8_ctrl: behavioural SRAM, word-level reference memory,
// directed cases followed by random word traffic.
module tb_wb_ram512x8_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [6:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        ram_wen_o;
    logic [8:0]  ram_adr_o;
    logic [7:0]  ram_dat_o;
    logic [7:0]  ram_dat_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_ram512x8_ctrl dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .ram_wen_o(ram_wen_o),
        .ram_adr_o(ram_adr_o),
        .ram_dat_o(ram_dat_o),
        .ram_dat_i(ram_dat_i)
    );

    // SRAM macro model: samples inputs on the edge, registered read data.
    logic [7:0]  sram [512];
    logic [16:0] wr_log [$];
    int          wen_cnt = 0;

    always @(posedge clk_i) begin
        if (ram_wen_o) begin
            sram[ram_adr_o] <= ram_dat_o;
            wr_log.push_back({ram_adr_o, ram_dat_o});
            wen_cnt <= wen_cnt + 1;
        end
        ram_dat_i <= sram[ram_adr_o];
    end

    // Word-level reference memory.
    logic [31:0] ref_mem [128];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_sel_i = '0;
        wb_dat_i = '0;
    endtask

    // One bus access as a classic master; inputs are scrambled after acceptance
    // and the strobe is released once ack is observed.
    task automatic bus_xfer(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        @(posedge clk_i); #1;
        wb_we_i  = 1'($urandom);
        wb_adr_i = 7'($urandom);
        wb_dat_i = $urandom;
        wb_sel_i = 4'($urandom);
        lat  = -1;
        rdat = 'x;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) begin
                lat  = n;
                rdat = wb_dat_o;
                break;
            end
        end
        idle_bus();
        @(posedge clk_i); #1;
        check("ack_one_cycle", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic do_write(input logic [6:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        int          lat;
        logic [16:0] exp_q [$];
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) exp_q.push_back({9'(adr * 4 + k), 8'(dat >> (8 * k))});
            if (sel[k]) ref_mem[adr][8*k +: 8] = dat[8*k +: 8];
        end
        wr_log.delete();
        bus_xfer(1'b1, adr, dat, sel, rd, lat);
        check("wr_ack_latency", 32'(lat), 32'd4);
        check("wr_ack_data_zero", rd, 32'd0);
        check("wr_byte_count", 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check("wr_byte_addr_data", 32'(wr_log[i]), 32'(exp_q[i]));
    endtask

    task automatic do_read(input logic [6:0] adr);
        logic [31:0] rd;
        int          lat;
        int          w0;
        w0 = wen_cnt;
        bus_xfer(1'b0, adr, $urandom, 4'($urandom), rd, lat);
        check("rd_ack_latency", 32'(lat), 32'd5);
        check("rd_data", rd, ref_mem[adr]);
        check("rd_no_wen", 32'(wen_cnt - w0), 32'd0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 512; i++) sram[i] = 8'h00;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        idle_bus();

        // Reset with toggling bus inputs.
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            wb_cyc_i = 1'($urandom); wb_stb_i = 1'($urandom); wb_we_i = 1'($urandom);
            wb_adr_i = 7'($urandom); wb_sel_i = 4'($urandom); wb_dat_i = $urandom;
        end
        @(posedge clk_i); #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_wen", 32'(ram_wen_o), 32'd0);
        check("rst_adr", 32'(ram_adr_o), 32'd0);
        check("rst_ram_dat", 32'(ram_dat_o), 32'd0);
        @(negedge clk_i);
        idle_bus();
        rst_i = 1'b0;

        // Full write, read back, partial write, read back.
        do_write(7'd5, 32'hDEADBEEF, 4'hF);
        do_read(7'd5);
        do_write(7'd5, 32'h11223344, 4'b0101);
        do_read(7'd5);
        check("partial_model", ref_mem[5], 32'hDE22BE44);

        // Top address must not wrap into word 0.
        do_write(7'd0, 32'hCAFEF00D, 4'hF);
        do_write(7'd127, 32'h01020304, 4'hF);
        do_read(7'd127);
        do_read(7'd0);

        // Reset during a write: only bytes 0 and 1 reach the SRAM.
        do_write(7'd9, 32'h0, 4'hF);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 7'd9; wb_dat_i = 32'hAABBCCDD; wb_sel_i = 4'hF;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        idle_bus();
        @(posedge clk_i); #1;
        check("midrst_wen", 32'(ram_wen_o), 32'd0);
        check("midrst_ack", 32'(wb_ack_o), 32'd0);
        rst_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o || ram_wen_o) bad++;
        end
        check("midrst_quiet", 32'(bad), 32'd0);
        ref_mem[9] = 32'h0000CCDD;
        do_read(7'd9);

        // Cycle dropped mid-write: all bytes still written, no ack.
        wr_log.delete();
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 7'd20; wb_dat_i = 32'h12345678; wb_sel_i = 4'hF;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        idle_bus();
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) bad++;
        end
        check("cycdrop_no_ack", 32'(bad), 32'd0);
        check("cycdrop_bytes", 32'(wr_log.size()), 32'd4);
        ref_mem[20] = 32'h12345678;
        do_read(7'd20);

        // Random traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            if (1'($urandom)) do_write(7'($urandom), $urandom, 4'($urandom));
            else              do_read(7'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
